mbox_ebox_resp: RTL

MBOX-side responder for the EBOX memory-cycle request issued by the MCL. It accepts a cycle request carrying the VMA, the read/write/pause/fetch qualifiers and the AR store data, then runs read, write, or read-pause-write (RPW) cycles on a simple handshaked memory port. It returns read data to the EBOX with a one-cycle transfer strobe and reports address-error page fails, NXM timeouts and protocol overruns.

---
 rtl/mbox_ebox_resp.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mbox_ebox_resp.sv
// MBOX-side responder for EBOX memory-cycle requests: runs read, write and
// read-pause-write cycles on a held-request memory port and reports errors.
module mbox_ebox_resp #(
  parameter int ADDR_W         = 23,
  parameter int DATA_W         = 36,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              RESET_N,
  input  logic              MBOX_CYC_REQ,
  input  logic [ADDR_W-1:0] VMA,
  input  logic              VMA_READ,
  input  logic              VMA_WRITE,
  input  logic              VMA_PAUSE,
  input  logic              VMA_FETCH,
  input  logic              VMA_ADR_ERR,
  input  logic [DATA_W-1:0] STORE_DATA,
  input  logic              ERR_CLR,
  output logic              MBOX_XFER,
  output logic              XFER_FETCH,
  output logic [DATA_W-1:0] MBOX_DATA,
  output logic              MBOX_BUSY,
  output logic              PAGE_FAIL,
  output logic              NXM_ERR,
  output logic              OVERRUN_ERR,
  output logic              MEM_REQ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic              MEM_ACK,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic [2:0]        dbg_state
);

  // Memory port handshake: MEM_REQ (with MEM_WRITE/MEM_ADDR/MEM_WDATA) is held
  // until the cycle in which MEM_ACK is high; the edge sampling MEM_ACK ends
  // the transfer. MEM_ACK outside RD/WR is ignored.

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_PAUSE = 3'd2,
    ST_WR    = 3'd3,
    ST_FAIL  = 3'd4
  } state_t;

  state_t           state;
  logic             lat_pause;
  logic             lat_write;
  logic             lat_fetch;
  logic [CNT_W-1:0] tmo_cnt;

  assign MBOX_BUSY = (state != ST_IDLE) || MBOX_XFER;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      state       <= ST_IDLE;
      lat_pause   <= 1'b0;
      lat_write   <= 1'b0;
      lat_fetch   <= 1'b0;
      tmo_cnt     <= '0;
      MBOX_XFER   <= 1'b0;
      XFER_FETCH  <= 1'b0;
      MBOX_DATA   <= '0;
      PAGE_FAIL   <= 1'b0;
      NXM_ERR     <= 1'b0;
      OVERRUN_ERR <= 1'b0;
      MEM_REQ     <= 1'b0;
      MEM_WRITE   <= 1'b0;
      MEM_ADDR    <= '0;
      MEM_WDATA   <= '0;
    end else begin
      MBOX_XFER  <= 1'b0;
      XFER_FETCH <= 1'b0;
      PAGE_FAIL  <= 1'b0;
      // Clear first so a same-cycle error set below takes priority.
      if (ERR_CLR) begin
        NXM_ERR     <= 1'b0;
        OVERRUN_ERR <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (MBOX_CYC_REQ) begin
            if (VMA_ADR_ERR || VMA_READ || VMA_WRITE) begin
              MEM_ADDR  <= VMA;
              MEM_WDATA <= STORE_DATA;
              lat_pause <= VMA_PAUSE;
              lat_write <= VMA_WRITE;
              lat_fetch <= VMA_FETCH;
            end
            if (VMA_ADR_ERR) begin
              state     <= ST_FAIL;
              PAGE_FAIL <= 1'b1;
            end else if (VMA_READ) begin
              state     <= ST_RD;
              MEM_REQ   <= 1'b1;
              MEM_WRITE <= 1'b0;
              tmo_cnt   <= '0;
            end else if (VMA_WRITE) begin
              state     <= ST_WR;
              MEM_REQ   <= 1'b1;
              MEM_WRITE <= 1'b1;
              tmo_cnt   <= '0;
            end else begin
              OVERRUN_ERR <= 1'b1;
            end
          end
        end
        ST_RD, ST_WR: begin
          if (MBOX_CYC_REQ) OVERRUN_ERR <= 1'b1;
          if (MEM_ACK) begin
            MEM_REQ   <= 1'b0;
            MBOX_XFER <= 1'b1;
            if (state == ST_RD) begin
              MBOX_DATA  <= MEM_RDATA;
              XFER_FETCH <= lat_fetch;
              state      <= (lat_pause || lat_write) ? ST_PAUSE : ST_IDLE;
            end else begin
              state <= ST_IDLE;
            end
          end else if (tmo_cnt == CNT_LAST) begin
            // No acknowledge in time: abandon the cycle, including any RPW write half.
            MEM_REQ <= 1'b0;
            NXM_ERR <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (MBOX_CYC_REQ) begin
            if (VMA_ADR_ERR) begin
              state     <= ST_FAIL;
              PAGE_FAIL <= 1'b1;
            end else if (VMA_WRITE) begin
              state     <= ST_WR;
              MEM_REQ   <= 1'b1;
              MEM_WRITE <= 1'b1;
              MEM_WDATA <= STORE_DATA;
              lat_write <= 1'b1;
              tmo_cnt   <= '0;
            end else begin
              OVERRUN_ERR <= 1'b1;
            end
          end
        end
        ST_FAIL: begin
          if (MBOX_CYC_REQ) OVERRUN_ERR <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
